// File: rtl/adler32_par.sv
// adler32_par: Adler-32 engine consuming up to DATA_WD/8 bytes per beat.
// Optional feature macro ADLER32_SEED_EN: when defined, start_i loads {s2,s1}
// from seed_i so a checksum can resume across split sources; otherwise start_i
// always loads 0x00000001 and seed_i is unused.
module adler32_par #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned CNT_WD  = $clog2(DATA_WD / 8) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [31:0]        seed_i,
    input  logic               val_i,
    output logic               rdy_o,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               lst_i,
    input  logic [CNT_WD-1:0]  lst_cnt_i,
    output logic               done_o,
    output logic               val_o,
    output logic [31:0]        dat_o,
    output logic [31:0]        len_o
);

    localparam int unsigned NUM_BYTES = DATA_WD / 8;
    localparam int unsigned SUM_WD    = 24;

    // Multiples of the Adler modulus used by the compare-and-subtract reducer
    localparam logic [SUM_WD-1:0] MOD1 = 24'd65521;
    localparam logic [SUM_WD-1:0] MOD2 = 24'd131042;
    localparam logic [SUM_WD-1:0] MOD4 = 24'd262084;
    localparam logic [SUM_WD-1:0] MOD8 = 24'd524168;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACTV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               acc;
    logic               done_d;
    logic               done_q;
    logic [15:0]        s1_q;
    logic [15:0]        s2_q;
    logic [31:0]        len_q;
    logic [31:0]        init_val;
    logic [CNT_WD-1:0]  n_bytes;
    logic [SUM_WD-1:0]  byte_sum;
    logic [SUM_WD-1:0]  wsum;
    logic [SUM_WD-1:0]  s1_sum;
    logic [SUM_WD-1:0]  s2_sum;
    logic [15:0]        s1_nxt;
    logic [15:0]        s2_nxt;

    // Exact x mod 65521 for any x < 16*65521; worst-case s2_sum with 8 bytes
    // and an unreduced seed is about 599000, well inside that range.
    function automatic logic [15:0] mod_reduce(input logic [SUM_WD-1:0] x);
        logic [SUM_WD-1:0] r;
        r = x;
        if (r >= MOD8) r = r - MOD8;
        if (r >= MOD4) r = r - MOD4;
        if (r >= MOD2) r = r - MOD2;
        if (r >= MOD1) r = r - MOD1;
        return 16'(r);
    endfunction

`ifdef ADLER32_SEED_EN
    assign init_val = seed_i;
`else
    logic unused_seed;
    assign unused_seed = ^seed_i;
    assign init_val    = 32'h0000_0001;
`endif

    // Byte count of this beat and the plain/weighted byte sums over it
    always_comb begin : beat_sum
        n_bytes  = CNT_WD'(NUM_BYTES);
        byte_sum = '0;
        wsum     = '0;
        if (lst_i && (lst_cnt_i != '0) && (lst_cnt_i <= CNT_WD'(NUM_BYTES))) begin
            n_bytes = lst_cnt_i;
        end
        for (int k = 0; k < int'(NUM_BYTES); k++) begin
            if (k < int'(n_bytes)) begin
                byte_sum = byte_sum + SUM_WD'(dat_i[DATA_WD-1-8*k -: 8]);
                wsum     = wsum + (SUM_WD'(n_bytes) - SUM_WD'(k))
                                  * SUM_WD'(dat_i[DATA_WD-1-8*k -: 8]);
            end
        end
        s1_sum = SUM_WD'(s1_q) + byte_sum;
        s2_sum = SUM_WD'(s2_q) + SUM_WD'(n_bytes) * SUM_WD'(s1_q) + wsum;
        s1_nxt = mod_reduce(s1_sum);
        s2_nxt = mod_reduce(s2_sum);
    end

    // Next-state and handshake decode
    always_comb begin : fsm_next
        state_d = state_q;
        rdy_o   = 1'b0;
        acc     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = ACTV;
            end
            ACTV: begin
                rdy_o = !start_i;
                acc   = val_i && !start_i;
                if (acc && lst_i) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = start_i ? ACTV : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Checksum, length and done registers; start_i reloads in any state
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (start_i) begin
                s1_q  <= init_val[15:0];
                s2_q  <= init_val[31:16];
                len_q <= '0;
            end else if (acc) begin
                s1_q  <= s1_nxt;
                s2_q  <= s2_nxt;
                len_q <= len_q + 32'(n_bytes);
            end
        end
    end

    assign done_o = done_q;
    assign val_o  = done_q;
    assign dat_o  = {s2_q, s1_q};
    assign len_o  = len_q;

endmodule

// File: tb/tb_adler32_par.sv
// tb_adler32_par: scoreboard bench for adler32_par at DATA_WD 32, 8 and 64.
module tb_adler32_par;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DATA_WD = 32 instance
    logic        start32, val32, rdy32, lst32, done32, valo32;
    logic [31:0] seed32, dat32, dato32, leno32;
    logic [2:0]  cnt32;
    // DATA_WD = 8 instance
    logic        start8, val8, rdy8, lst8, done8, valo8;
    logic [7:0]  dat8;
    logic [0:0]  cnt8;
    logic [31:0] dato8, leno8;
    // DATA_WD = 64 instance
    logic        start64, val64, rdy64, lst64, done64, valo64;
    logic [63:0] dat64;
    logic [3:0]  cnt64;
    logic [31:0] dato64, leno64;

    adler32_par #(.DATA_WD(32)) u_dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .seed_i(seed32), .val_i(val32),
        .rdy_o(rdy32), .dat_i(dat32), .lst_i(lst32), .lst_cnt_i(cnt32),
        .done_o(done32), .val_o(valo32), .dat_o(dato32), .len_o(leno32)
    );
    adler32_par #(.DATA_WD(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .seed_i(32'd0), .val_i(val8),
        .rdy_o(rdy8), .dat_i(dat8), .lst_i(lst8), .lst_cnt_i(cnt8),
        .done_o(done8), .val_o(valo8), .dat_o(dato8), .len_o(leno8)
    );
    adler32_par #(.DATA_WD(64)) u_dut64 (
        .clk(clk), .rst(rst), .start_i(start64), .seed_i(32'd0), .val_i(val64),
        .rdy_o(rdy64), .dat_i(dat64), .lst_i(lst64), .lst_cnt_i(cnt64),
        .done_o(done64), .val_o(valo64), .dat_o(dato64), .len_o(leno64)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [63:0] q32[$];
    logic [63:0] q8[$];
    logic [63:0] q64[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitors: every done pulse pops one expected {checksum,len}
    task automatic mon(input string name, input logic vo, input logic [31:0] d,
                       input logic [31:0] l, inout logic [63:0] q[$]);
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s unexpected done dat_o=%h len_o=%0d", name, d, l);
        end else begin
            chk(name, {31'd0, vo, d, l}, {32'd1, q.pop_front()});
        end
    endtask

    always @(negedge clk) if (done32 === 1'b1) mon("result32", valo32, dato32, leno32, q32);
    always @(negedge clk) if (done8  === 1'b1) mon("result8",  valo8,  dato8,  leno8,  q8);
    always @(negedge clk) if (done64 === 1'b1) mon("result64", valo64, dato64, leno64, q64);

    // All tasks are entered and left just after a falling edge
    task automatic do_start(input logic [31:0] sd);
        start32 = 1'b1;
        seed32  = sd;
        val32   = 1'b0;
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [2:0] c);
        int waited;
        waited = 0;
        val32 = 1'b1; dat32 = d; lst32 = l; cnt32 = c;
        #1;
        while (!rdy32 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("beat_ready", 96'(rdy32), 96'd1);
        if (!rdy32) begin
            val32 = 1'b0; lst32 = 1'b0;
            @(negedge clk);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        val32 = 1'b0; lst32 = 1'b0;
        if (l) chk("done_latency", 96'(done32), 96'd1);
    endtask

    task automatic gap(input int n);
        val32 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start32 = 0; seed32 = 0; val32 = 0; dat32 = 0; lst32 = 0; cnt32 = 0;
        start8  = 0; val8  = 0; dat8  = 0; lst8  = 0; cnt8  = 0;
        start64 = 0; val64 = 0; dat64 = 0; lst64 = 0; cnt64 = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {29'd0, rdy32, done32, valo32, dato32, leno32}, 96'd0);
        rst = 1'b0;
        @(negedge clk);

        // val_i in IDLE is ignored
        val32 = 1'b1; dat32 = 32'hDEADBEEF; lst32 = 1'b1; cnt32 = 3'd4;
        #1 chk("idle_rdy", 96'(rdy32), 96'd0);
        repeat (3) @(negedge clk);
        val32 = 1'b0; lst32 = 1'b0;

        // "abc" in one partial beat
        q32.push_back({32'h024D0127, 32'd3});
        do_start(32'd0);
        send(32'h61626300, 1'b1, 3'd3);
        gap(2);

        // "Wikipedia" with idle gaps between beats
        q32.push_back({32'h11E60398, 32'd9});
        do_start(32'd0);
        send(32'h57696B69, 1'b0, 3'd0);
        gap(2);
        send(32'h70656469, 1'b0, 3'd0);
        gap(1);
        send(32'h61000000, 1'b1, 3'd1);
        gap(2);

        // lst_cnt_i of 0 means a full beat: "abcd"
        q32.push_back({32'h03D8018B, 32'd4});
        do_start(32'd0);
        send(32'h61626364, 1'b1, 3'd0);
        gap(2);

        // start_i mid-stream aborts; beat offered with start is not taken
        do_start(32'd0);
        send(32'hDEADBEEF, 1'b0, 3'd0);
        send(32'h01020304, 1'b0, 3'd0);
        start32 = 1'b1; val32 = 1'b1; dat32 = 32'hFFFFFFFF; lst32 = 1'b1; cnt32 = 3'd4;
        #1 chk("rdy_during_start", 96'(rdy32), 96'd0);
        @(negedge clk);
        start32 = 1'b0; val32 = 1'b0; lst32 = 1'b0;
        q32.push_back({32'h024D0127, 32'd3});
        send(32'h61626300, 1'b1, 3'd3);
        gap(2);

        // reset mid-stream clears everything, next stream is normal
        do_start(32'd0);
        send(32'h61626300, 1'b0, 3'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midstream_reset", {29'd0, rdy32, done32, valo32, dato32, leno32}, 96'd0);
        rst = 1'b0;
        @(negedge clk);
        q32.push_back({32'h024D0127, 32'd3});
        do_start(32'd0);
        send(32'h61626300, 1'b1, 3'd3);
        gap(2);

        // start_i during DONE; the beat offered meanwhile waits
        q32.push_back({32'h024D0127, 32'd3});
        do_start(32'd0);
        send(32'h61626300, 1'b1, 3'd3);
        start32 = 1'b1; val32 = 1'b1; dat32 = 32'h57696B69; lst32 = 1'b0;
        #1 chk("rdy_in_done", 96'(rdy32), 96'd0);
        @(negedge clk);
        start32 = 1'b0;
        q32.push_back({32'h11E60398, 32'd9});
        #1 chk("rdy_after_done_start", 96'(rdy32), 96'd1);
        send(32'h57696B69, 1'b0, 3'd0);
        send(32'h70656469, 1'b0, 3'd0);
        send(32'h61000000, 1'b1, 3'd1);
        gap(2);

`ifdef ADLER32_SEED_EN
        // resume from a seed
        q32.push_back({32'h024D0127, 32'd1});
        do_start(32'h012600C4);
        send(32'h63000000, 1'b1, 3'd1);
        gap(1);
        // unreduced seed halves
        q32.push_back({32'hFFF00000, 32'd1});
        do_start(32'hFFF0FFF0);
        send(32'h01000000, 1'b1, 3'd1);
        gap(2);
`endif

        // 6000 bytes of 0xFF, one byte per beat
        q8.push_back({32'hA49759EA, 32'd6000});
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; val8 = 1'b1; dat8 = 8'hFF; cnt8 = 1'b1;
        #1 chk("rdy8", 96'(rdy8), 96'd1);
        for (int i = 0; i < 6000; i++) begin
            lst8 = (i == 5999);
            @(negedge clk);
        end
        val8 = 1'b0; lst8 = 1'b0;
        chk("done8_latency", 96'(done8), 96'd1);
        @(negedge clk);

        // 6000 bytes of 0xFF, eight bytes per beat
        q64.push_back({32'hA49759EA, 32'd6000});
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0; val64 = 1'b1; dat64 = 64'hFFFF_FFFF_FFFF_FFFF; cnt64 = 4'd8;
        #1 chk("rdy64", 96'(rdy64), 96'd1);
        for (int i = 0; i < 750; i++) begin
            lst64 = (i == 749);
            @(negedge clk);
        end
        val64 = 1'b0; lst64 = 1'b0;
        chk("done64_latency", 96'(done64), 96'd1);

        repeat (3) @(negedge clk);
        chk("pending32", 96'(q32.size()), 96'd0);
        chk("pending8",  96'(q8.size()),  96'd0);
        chk("pending64", 96'(q64.size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
